// File: rtl/led_driver_if.sv
// Bundles the LED driver control inputs and status outputs.
// The master side (upstream controller) drives blink/mode/level; the slave side is the driver.
interface led_driver_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                blink_i;
  logic [1:0]          mode_i;
  logic [PWM_BITS-1:0] level_i;
  logic                led_o;
  logic                period_o;
  logic [PWM_BITS-1:0] duty_o;

  modport master (
    output blink_i,
    output mode_i,
    output level_i,
    input  led_o,
    input  period_o,
    input  duty_o
  );

  modport slave (
    input  blink_i,
    input  mode_i,
    input  level_i,
    output led_o,
    output period_o,
    output duty_o
  );
endinterface

// File: rtl/led_driver.sv
// PWM LED driver with OFF/ON/DIM/BREATHE modes; mode and duty only change at period boundaries.
// A breathing FSM ramps the duty up and down with optional hold periods at each extreme.
module led_driver #(
  parameter int unsigned PRESC    = 64,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned HOLD     = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  led_driver_if.slave bus
);

  localparam int unsigned         PrescW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(PRESC - 1);
  localparam logic [PWM_BITS-1:0] AllOnes   = '1;
  localparam logic [7:0]          HoldLast  = (HOLD == 0) ? 8'd0 : 8'(HOLD - 1);

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeOn      = 2'b01;
  localparam logic [1:0] ModeDim     = 2'b10;
  localparam logic [1:0] ModeBreathe = 2'b11;

  typedef enum logic [2:0] {StIdle, StUp, StHoldHi, StDown, StHoldLo} state_e;

  logic [PrescW-1:0]   presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          hold_q, hold_d;
  state_e              state_q, state_d;
  logic                led_q, led_d;
  logic                period_q, period_d;

  logic                step, pb, pwm, raw;
  logic [PWM_BITS-1:0] duty_inc, duty_dec;

  always_comb begin
    // With PRESC=1 PrescLast is 0 and presc_q never leaves 0, so every cycle is a step.
    step     = (presc_q == PrescLast);
    presc_d  = step ? '0 : presc_q + 1'b1;
    cnt_d    = step ? cnt_q + 1'b1 : cnt_q;
    pb       = step && (cnt_q == AllOnes);
    // Registered one cycle early so period_o lines up with the boundary cycle itself.
    period_d = (presc_d == PrescLast) && (cnt_d == AllOnes);

    pwm = (duty_q == AllOnes) || (cnt_q < duty_q);
    unique case (mode_q)
      ModeOff:     raw = 1'b0;
      ModeOn:      raw = bus.blink_i;
      ModeDim:     raw = pwm & bus.blink_i;
      ModeBreathe: raw = pwm & bus.blink_i;
      default:     raw = 1'b0;
    endcase
    led_d = raw;

    duty_inc = (duty_q == AllOnes) ? duty_q : duty_q + 1'b1;
    duty_dec = (duty_q == '0) ? duty_q : duty_q - 1'b1;

    mode_d  = mode_q;
    duty_d  = duty_q;
    state_d = state_q;
    hold_d  = hold_q;

    if (pb) begin
      mode_d = bus.mode_i;
      if (bus.mode_i != ModeBreathe) begin
        state_d = StIdle;
        hold_d  = 8'd0;
        duty_d  = (bus.mode_i == ModeDim) ? bus.level_i : '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_d = StUp;
            duty_d  = '0;
          end
          StUp: begin
            duty_d = duty_inc;
            hold_d = 8'd0;
            if (duty_inc == AllOnes) state_d = (HOLD == 0) ? StDown : StHoldHi;
          end
          StHoldHi: begin
            if (hold_q == HoldLast) state_d = StDown;
            else                    hold_d  = hold_q + 8'd1;
          end
          StDown: begin
            duty_d = duty_dec;
            hold_d = 8'd0;
            if (duty_dec == '0) state_d = (HOLD == 0) ? StUp : StHoldLo;
          end
          StHoldLo: begin
            if (hold_q == HoldLast) state_d = StUp;
            else                    hold_d  = hold_q + 8'd1;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      mode_q   <= ModeOff;
      hold_q   <= 8'd0;
      state_q  <= StIdle;
      led_q    <= 1'b0;
      period_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      led_q    <= led_d;
      period_q <= period_d;
    end
  end

  assign bus.led_o    = led_q;
  assign bus.period_o = period_q;
  assign bus.duty_o   = duty_q;

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver (PRESC=2, PWM_BITS=3, HOLD=2): a table of steady modes plus hand-written
// breathing, mid-period mode change and mid-breath reset sequences, checked via a cycle-stamped queue.
module tb_led_driver;

  localparam int unsigned PRESC    = 2;
  localparam int unsigned PWM_BITS = 3;
  localparam int unsigned HOLD     = 2;

  localparam int KLed    = 0;
  localparam int KPeriod = 1;
  localparam int KDuty   = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  led_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_driver #(
    .PRESC   (PRESC),
    .PWM_BITS(PWM_BITS),
    .HOLD    (HOLD)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  // Cycle 0 is the first cycle with rst_i low.
  always @(posedge clk_i) cyc <= rst_i ? 0 : cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] level;
    logic       blink;
    int         exp_hi;
    int         exp_duty;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  function automatic string kind_name(int k);
    case (k)
      KLed:    return "led_o";
      KPeriod: return "period_o";
      default: return "duty_o";
    endcase
  endfunction

  function automatic int actual(int k);
    case (k)
      KLed:    return int'(bus.led_o);
      KPeriod: return int'(bus.period_o);
      default: return int'(bus.duty_o);
    endcase
  endfunction

  // Expected duty of breathing period p after reset (period 0 is spent in OFF before sampling).
  function automatic int bduty(int p);
    int seq[18];
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    if (p == 0) return 0;
    return seq[(p - 1) % 18];
  endfunction

  task automatic push(input int c, input int k, input int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   a;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s_unchecked cyc=%0d want %0d (cycle passed without check)",
                 kind_name(e.kind), e.cyc, e.val);
      end else begin
        a = actual(e.kind);
        if (a != e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got %0d want %0d", kind_name(e.kind), cyc, a, e.val);
        end
      end
    end
  endtask

  // Check at the falling edge, then return #1 after the next rising edge.
  task automatic step();
    @(negedge clk_i);
    drain();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      step();
      guard++;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b01, 3'd0, 1'b1, 16, 0};
    vecs[1] = '{2'b01, 3'd5, 1'b0,  0, 0};
    vecs[2] = '{2'b00, 3'd7, 1'b1,  0, 0};
    vecs[3] = '{2'b10, 3'd3, 1'b1,  6, 3};
    vecs[4] = '{2'b10, 3'd7, 1'b1, 16, 7};
    vecs[5] = '{2'b10, 3'd0, 1'b1,  0, 0};
    vecs[6] = '{2'b10, 3'd5, 1'b0,  0, 5};
    vecs[7] = '{2'b10, 3'd1, 1'b1,  2, 1};
    vecs[8] = '{2'b10, 3'd6, 1'b1, 12, 6};

    bus.blink_i = 1'b0;
    bus.mode_i  = 2'b00;
    bus.level_i = '0;

    // Steady modes: first period runs as OFF, the sampled mode applies from cycle 16.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.mode_i  = vecs[v].mode;
      bus.level_i = vecs[v].level;
      bus.blink_i = vecs[v].blink;
      for (int c = 0; c <= 48; c++) begin
        push(c, KLed, (c <= 16) ? 0 : int'(((c - 17) % 16) < vecs[v].exp_hi));
        push(c, KPeriod, int'((c % 16) == 15));
        push(c, KDuty, (c <= 15) ? 0 : vecs[v].exp_duty);
      end
      run_to(49);
    end

    // Breathing over two full breaths, with a blink dropout inside the duty-7 window.
    do_reset();
    bus.mode_i  = 2'b11;
    bus.level_i = 3'd2;
    bus.blink_i = 1'b1;
    for (int c = 0; c <= 41 * 16; c++) begin
      int p, i, d, lit;
      if (c == 0) begin
        lit = 0;
      end else begin
        p   = (c - 1) / 16;
        i   = (c - 1) % 16;
        d   = bduty(p);
        lit = (p != 0 && ((d == 7) || ((i / 2) < d)) && !((c - 1) >= 130 && (c - 1) <= 137))
              ? 1 : 0;
      end
      push(c, KLed, lit);
      push(c, KPeriod, int'((c % 16) == 15));
      push(c, KDuty, bduty(c / 16));
    end
    run_to(130);
    bus.blink_i = 1'b0;
    run_to(138);
    bus.blink_i = 1'b1;
    run_to(41 * 16 + 1);

    // DIM 3, switch to OFF mid-period: current and first-sampled periods unchanged.
    do_reset();
    bus.mode_i  = 2'b10;
    bus.level_i = 3'd3;
    bus.blink_i = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      push(c, KLed, (c >= 17 && c <= 32) ? int'((c - 17) < 6) : 0);
      push(c, KPeriod, int'((c % 16) == 15));
      push(c, KDuty, (c >= 16 && c <= 31) ? 3 : 0);
    end
    run_to(21);
    bus.mode_i  = 2'b00;
    bus.level_i = 3'd7;
    run_to(49);

    // One-cycle reset mid-breath at duty 5.
    do_reset();
    bus.mode_i  = 2'b11;
    bus.blink_i = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      push(c, KPeriod, int'((c % 16) == 15));
      push(c, KDuty, bduty(c / 16));
    end
    push(100, KLed, 1);
    run_to(100);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      push(c, KLed, 0);
      push(c, KPeriod, int'(c == 15));
      push(c, KDuty, 0);
    end
    run_to(17);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
